// File: rtl/tx_arbiter_if.sv
// TX arbiter bundle: scheduler/prefetch request channels plus the shared TX status and pin outputs.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface tx_arbiter_if #(
  parameter int NSHIFT   = 2,
  parameter int CMD_BITS = 2,
  parameter int CNT_W    = 4
);
  logic                sched_cmd_valid;
  logic [CMD_BITS-1:0] sched_cmd;
  logic                sched_reserve;
  logic [NSHIFT-1:0]   sched_data;
  logic                sched_started;
  logic                pf_cmd_valid;
  logic [NSHIFT-1:0]   pf_data;
  logic                pf_started;
  logic                tx_active;
  logic                tx_data_next;
  logic [CNT_W-1:0]    tx_counter;
  logic                tx_done;
  logic                tx_owner;
  logic [NSHIFT-1:0]   tx_pins;

  modport slave (
    input  sched_cmd_valid, sched_cmd, sched_reserve, sched_data, pf_cmd_valid, pf_data,
    output sched_started, pf_started, tx_active, tx_data_next, tx_counter, tx_done,
           tx_owner, tx_pins
  );

  modport master (
    output sched_cmd_valid, sched_cmd, sched_reserve, sched_data, pf_cmd_valid, pf_data,
    input  sched_started, pf_started, tx_active, tx_data_next, tx_counter, tx_done,
           tx_owner, tx_pins
  );
endinterface

// File: rtl/tx_arbiter.sv
// Shares the serial TX pins between scheduler and prefetch: grant in IDLE, 2 header cycles, then payload.
// Grant/started same cycle; READ_16 done 10 cycles later; no backpressure, owner must supply a chunk on data_next.
module tx_arbiter #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int CMD_BITS       = 2
) (
  input  logic        clk,
  input  logic        reset,
  tx_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(PAYLOAD_CYCLES) + 1;
  localparam logic [CMD_BITS-1:0] CMD_READ_16 = CMD_BITS'(0);
  localparam logic [CMD_BITS-1:0] CMD_WRITE_8 = CMD_BITS'(1);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0]    counter_q, counter_d;

  logic              sched_win, pf_win;
  logic              active, data_next, done;
  logic [NSHIFT-1:0] pins;
  logic [CNT_W-1:0]  last_cnt;

  // Counter runs 0,1 through the header, so payload ends at 1 + payload length.
  assign last_cnt = (cmd_q == CMD_WRITE_8) ? CNT_W'(PAYLOAD_CYCLES / 2 + 1)
                                           : CNT_W'(PAYLOAD_CYCLES + 1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    counter_d    = counter_q;
    sched_win    = 1'b0;
    pf_win       = 1'b0;
    active       = 1'b0;
    data_next    = 1'b0;
    done         = 1'b0;
    pins         = '0;
    case (state_q)
      IDLE: begin
        // Reserve favours the scheduler; otherwise the loser of the last grant wins a tie.
        sched_win = bus.sched_cmd_valid &&
                    (bus.sched_reserve || !bus.pf_cmd_valid || last_grant_q);
        pf_win    = bus.pf_cmd_valid && !bus.sched_reserve && !sched_win;
        if (sched_win || pf_win) begin
          owner_d      = pf_win;
          last_grant_d = pf_win;
          cmd_d        = sched_win ? bus.sched_cmd : CMD_READ_16;
          counter_d    = '0;
          state_d      = HDR0;
        end
      end
      HDR0: begin
        active    = 1'b1;
        pins      = NSHIFT'(1);
        counter_d = CNT_W'(1);
        state_d   = HDR1;
      end
      HDR1: begin
        active    = 1'b1;
        pins      = NSHIFT'(cmd_q);
        counter_d = CNT_W'(2);
        state_d   = PAYLOAD;
      end
      PAYLOAD: begin
        active    = 1'b1;
        data_next = 1'b1;
        pins      = owner_q ? bus.pf_data : bus.sched_data;
        if (counter_q == last_cnt) begin
          done      = 1'b1;
          counter_d = '0;
          state_d   = IDLE;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_q        <= '0;
      counter_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      counter_q    <= counter_d;
    end
  end

  // Outputs are forced low while reset is held so an aborted message never shows tx_done.
  assign bus.sched_started = sched_win && !reset;
  assign bus.pf_started    = pf_win && !reset;
  assign bus.tx_active     = active && !reset;
  assign bus.tx_data_next  = data_next && !reset;
  assign bus.tx_done       = done && !reset;
  assign bus.tx_owner      = active && !reset && owner_q;
  assign bus.tx_counter    = reset ? '0 : counter_q;
  assign bus.tx_pins       = reset ? '0 : pins;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: message-level reference model checked every cycle plus literal checks.
module tb_tx_arbiter;
  localparam int NSHIFT = 2, PC = 8, CMD_BITS = 2, CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NSHIFT(NSHIFT), .CMD_BITS(CMD_BITS), .CNT_W(CNT_W)) bus ();
  tx_arbiter #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PC), .CMD_BITS(CMD_BITS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one message record (owner, cmd, cycle index) plus who was granted last.
  logic       m_busy, m_owner, m_last;
  logic [1:0] m_cmd;
  int         m_k, m_len;
  logic       e_ss, e_ps, e_act, e_dn, e_done, e_own;
  int         e_cnt;
  logic [1:0] e_pins;

  always @(negedge clk) begin
    e_ss = 0; e_ps = 0; e_act = 0; e_dn = 0; e_done = 0; e_own = 0; e_cnt = 0; e_pins = 0;
    if (reset) begin
      m_busy = 0; m_last = 1; m_k = 0; m_owner = 0; m_cmd = 0;
    end else if (!m_busy) begin
      if (bus.sched_cmd_valid && (bus.sched_reserve || !bus.pf_cmd_valid || m_last)) begin
        e_ss = 1; m_busy = 1; m_owner = 0; m_cmd = bus.sched_cmd; m_last = 0; m_k = 0;
      end else if (bus.pf_cmd_valid && !bus.sched_reserve) begin
        e_ps = 1; m_busy = 1; m_owner = 1; m_cmd = 0; m_last = 1; m_k = 0;
      end
    end else begin
      m_len = (m_cmd == 2'd1) ? PC / 2 : PC;
      e_act = 1; e_own = m_owner; e_cnt = m_k;
      if (m_k == 0) e_pins = 2'b01;
      else if (m_k == 1) e_pins = m_cmd;
      else begin
        e_dn = 1;
        e_pins = m_owner ? bus.pf_data : bus.sched_data;
      end
      if (m_k == m_len + 1) begin
        e_done = 1; m_busy = 0;
      end else begin
        m_k++;
      end
    end
    chk("sched_started", bus.sched_started, e_ss);
    chk("pf_started", bus.pf_started, e_ps);
    chk("tx_active", bus.tx_active, e_act);
    chk("tx_data_next", bus.tx_data_next, e_dn);
    chk("tx_done", bus.tx_done, e_done);
    chk("tx_owner", bus.tx_owner, e_own);
    chk("tx_counter", bus.tx_counter, e_cnt);
    chk("tx_pins", bus.tx_pins, e_pins);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the tx_done cycle.
  task automatic wait_done(input string name);
    logic found;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (bus.tx_done) begin
        found = 1;
        break;
      end
      tick();
    end
    chk(name, found, 1);
  endtask

  logic [1:0] w8 [1:6];

  initial begin
    int d_at, p_at, dn, n_act, n_done, n_ss;
    logic found;
    w8[1] = 2'b01; w8[2] = 2'b01; w8[3] = 2'd0; w8[4] = 2'd1; w8[5] = 2'd2; w8[6] = 2'd3;
    reset = 1;
    bus.sched_cmd_valid = 0; bus.sched_cmd = 0; bus.sched_reserve = 0; bus.sched_data = 0;
    bus.pf_cmd_valid = 0; bus.pf_data = 0;
    repeat (3) tick();
    smp();
    chk("rst_active", bus.tx_active, 0);
    chk("rst_pins", bus.tx_pins, 0);
    tick();
    reset = 0;
    smp();
    chk("idle_counter", bus.tx_counter, 0);

    // Lone prefetch request: READ_16 timeline.
    tick();
    bus.pf_cmd_valid = 1;
    smp();
    chk("t1_pf_started", bus.pf_started, 1);
    for (int i = 1; i <= 11; i++) begin
      tick();
      bus.pf_cmd_valid = 0;
      bus.pf_data = 2'(i);
      smp();
      if (i == 1) chk("t1_hdr0_pins", bus.tx_pins, 1);
      else if (i == 2) chk("t1_hdr1_pins", bus.tx_pins, 0);
      else if (i <= 10) chk("t1_payload_pins", bus.tx_pins, i % 4);
      chk("t1_done", bus.tx_done, (i == 10));
      if (i == 10) chk("t1_done_counter", bus.tx_counter, 9);
      if (i == 11) chk("t1_active_after", bus.tx_active, 0);
    end

    // Both request, last grant was prefetch: scheduler first, prefetch right after.
    tick();
    bus.sched_cmd_valid = 1; bus.sched_cmd = 2; bus.pf_cmd_valid = 1;
    smp();
    chk("t3_sched_first", bus.sched_started, 1);
    chk("t3_pf_waits", bus.pf_started, 0);
    tick();
    bus.sched_cmd_valid = 0;
    d_at = -100; p_at = -1;
    for (int c = 0; c < 40; c++) begin
      smp();
      if (bus.tx_done) d_at = c;
      if (bus.pf_started) begin
        p_at = c;
        break;
      end
      tick();
    end
    chk("t3_pf_granted", (p_at >= 0), 1);
    chk("t3_gap", p_at - d_at, 1);
    tick();
    bus.pf_cmd_valid = 0;
    wait_done("t3_pf_done");
    tick();
    bus.sched_cmd_valid = 1; bus.sched_cmd = 2; bus.pf_cmd_valid = 1;
    smp();
    chk("t3_rr_sched_again", bus.sched_started, 1);
    tick();
    bus.sched_cmd_valid = 0; bus.pf_cmd_valid = 0;
    wait_done("t3_sched_done");

    // Reserve blocks a lone prefetch; scheduler then wins immediately with WRITE_8.
    tick();
    bus.sched_reserve = 1; bus.pf_cmd_valid = 1; bus.pf_data = 2'd3;
    for (int c = 0; c < 20; c++) begin
      smp();
      chk("t4_no_pf_started", bus.pf_started, 0);
      chk("t4_inactive", bus.tx_active, 0);
      tick();
    end
    bus.sched_cmd_valid = 1; bus.sched_cmd = 1;
    smp();
    chk("t4_sched_now", bus.sched_started, 1);
    dn = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus.sched_cmd_valid = 0;
      bus.sched_data = (i >= 3) ? 2'(i - 3) : 2'd0;
      smp();
      dn += int'(bus.tx_data_next);
      if (i <= 6) chk("t2_pins", bus.tx_pins, w8[i]);
      if (i == 6) begin
        chk("t2_done", bus.tx_done, 1);
        chk("t2_done_counter", bus.tx_counter, 5);
      end
    end
    chk("t2_data_next_cycles", dn, 4);
    tick();
    bus.sched_reserve = 0; bus.pf_cmd_valid = 0;

    // Reset in the middle of a payload aborts the message.
    tick();
    bus.pf_cmd_valid = 1;
    smp();
    tick();
    bus.pf_cmd_valid = 0;
    found = 0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      n_done += int'(bus.tx_done);
      if (bus.tx_counter == 5) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t5_reached_cnt5", found, 1);
    tick();
    reset = 1;
    smp();
    n_done += int'(bus.tx_done);
    tick();
    reset = 0;
    smp();
    chk("t5_active_after_rst", bus.tx_active, 0);
    chk("t5_pins_after_rst", bus.tx_pins, 0);
    chk("t5_no_done", n_done + int'(bus.tx_done), 0);
    tick();
    bus.pf_cmd_valid = 1;
    smp();
    chk("t5_pf_restart", bus.pf_started, 1);
    n_act = 0; n_done = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      bus.pf_cmd_valid = 0;
      smp();
      n_act += int'(bus.tx_active);
      if (bus.tx_done) begin
        n_done++;
        chk("t5_done_counter", bus.tx_counter, 9);
      end
    end
    chk("t5_full_length", n_act, 10);
    chk("t5_done_count", n_done, 1);

    // One-cycle scheduler pulse during a prefetch message is withdrawn.
    tick();
    bus.pf_cmd_valid = 1;
    smp();
    tick();
    bus.pf_cmd_valid = 0;
    tick();
    tick();
    bus.sched_cmd_valid = 1; bus.sched_cmd = 0;
    n_ss = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      n_ss += int'(bus.sched_started);
      tick();
      bus.sched_cmd_valid = 0;
    end
    chk("t6_no_sched_started", n_ss, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Owns the serial TX pins and shares them between two requesters: the instruction scheduler and the prefetch unit.
- Arbitrates each message, then frames it: a 2-cycle header followed by a command-dependent number of NSHIFT-bit payload cycles.
- Pulls payload data from the granted requester one chunk per cycle.
- Provides the tx_command_started, tx_active, tx_data_next, tx_counter and tx_done handshakes that the scheduler and prefetcher consume.

Parameters:
- NSHIFT, 2, bits sent per cycle on tx_pins.
- PAYLOAD_CYCLES, 8, payload cycles of a 16-bit message (16/NSHIFT).
- CMD_BITS, 2, command code width (equals NSHIFT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sched_cmd_valid  in  1  scheduler requests a message
- sched_cmd  in  CMD_BITS  scheduler command code
- sched_reserve  in  1  scheduler holds priority; blocks new prefetch grants
- sched_data  in  NSHIFT  scheduler payload chunk
- sched_started  out  1  pulse: scheduler request accepted
- pf_cmd_valid  in  1  prefetch requests a message (always READ_16)
- pf_data  in  NSHIFT  prefetch payload chunk
- pf_started  out  1  pulse: prefetch request accepted
- tx_active  out  1  message in progress (header or payload)
- tx_data_next  out  1  owner must present its next chunk this cycle, then advance
- tx_counter  out  $clog2(PAYLOAD_CYCLES)+1  cycle index within message
- tx_done  out  1  pulse in the last payload cycle
- tx_owner  out  1  0 = scheduler, 1 = prefetch; valid while tx_active
- tx_pins  out  NSHIFT  serial output

Behaviour:
- Command codes and payload length:
  - 0 = READ_16: PAYLOAD_CYCLES payload cycles.
  - 1 = WRITE_8: PAYLOAD_CYCLES/2 payload cycles.
  - 2 = WRITE_16: PAYLOAD_CYCLES payload cycles.
  - 3: treated as READ_16.
- States: IDLE, HDR0, HDR1, PAYLOAD.
- Reset: state IDLE; last_grant = prefetch; all outputs 0; tx_pins = 0.
- Reset mid-message: the message is aborted, outputs return to 0 on the next cycle, and no tx_done is issued.
- IDLE grant rules:
  - Only sched_cmd_valid: grant scheduler.
  - Only pf_cmd_valid: grant prefetch, unless sched_reserve is high, in which case no grant.
  - Both requesting: scheduler wins if sched_reserve is high; otherwise the requester not granted last time wins (round robin).
- On grant (same cycle):
  - Pulse the winner's *_started combinationally.
  - Latch owner and command; next state HDR0.
  - Requesters must hold valid and cmd until started. Dropping valid before started withdraws the request.
- HDR0: tx_pins = 2'b01 (start marker); tx_counter = 0.
- HDR1: tx_pins = latched cmd; tx_counter = 1.
- PAYLOAD:
  - tx_data_next = 1.
  - tx_pins = owner's data input, combinational passthrough.
  - tx_counter increments by 1 each cycle from 2.
  - The last payload cycle is tx_counter = 1 + payload length; tx_done = 1 in that cycle; next state IDLE.
- Latency: grant cycle T; HDR0 at T+1; first payload at T+3; READ_16 done at T+10.
- Gap: at least 1 IDLE cycle between messages. No grant is issued in the cycle tx_done is high.
- tx_active = state != IDLE.
- Only one requester receives data_next; the other's data input is ignored.
- sched_reserve does not preempt an in-flight prefetch message; it only affects the next grant.
- IDLE: tx_pins = 0, tx_data_next = 0, tx_counter = 0.

Test Plan:
- Reset, then pf_cmd_valid=1 alone → pf_started pulses at T; tx_pins shows 01 at T+1 and 00 at T+2; pf_data sampled at T+3..T+10; tx_done at T+10 with tx_counter=9; tx_active low at T+11.
- sched_cmd=1 (WRITE_8) with sched_data cycling 0,1,2,3 → tx_pins 01,01,0,1,2,3; tx_done at counter 5; exactly 4 data_next cycles.
- Both valid, sched_reserve=0, last grant = prefetch → scheduler granted first; after its tx_done plus 1 idle cycle, prefetch is granted. Repeating the test alternates the winner.
- sched_reserve=1, sched_cmd_valid=0, pf_cmd_valid=1 for 20 cycles → no pf_started and tx_active stays 0. Raise sched_cmd_valid → scheduler granted in the same cycle.
- Assert reset during PAYLOAD (counter=5) → next cycle tx_active=0, tx_pins=0, no tx_done. A subsequent pf request gets a full 10-cycle message.
- sched_cmd_valid pulsed for one cycle while a prefetch message is active → no sched_started is ever issued (request withdrawn).
